// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: clock-rate constants and
// a constant-evaluable ceiling log2 used to size the per-lane counters.
package input_conditioner_pkg;

    localparam int CLK_HZ    = 50_000_000;
    localparam int MS_CYCLES = CLK_HZ / 1000;

    // Ceiling log2; clog2(1) == 0, so counters sized clog2(n)+1 always hold n.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-to-logic bus of the input conditioner. The slave side is the
// conditioner itself; the master side owns the raw pins and consumes the
// conditioned level, edge pulses and long-press flags.
interface input_conditioner_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] pin_in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] held;

    modport master (output pin_in, input level, rise, fall, held);
    modport slave  (input pin_in, output level, rise, fall, held);
endinterface

// File: rtl/input_channel.sv
// One conditioning lane: synchronizer chain, debounce counter with
// registered edge pulses, and a saturating long-press counter.
module input_channel
    import input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = MS_CYCLES,
    parameter int   HOLD_CYCLES     = CLK_HZ,
    parameter logic INIT            = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_held
);
    localparam int DW = clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = clog2(HOLD_CYCLES) + 1;
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HC_MAX  = HW'(HOLD_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_dc;
    logic [HW-1:0]          r_hc;
    logic                   r_level, r_rise, r_fall, r_held;
    logic                   w_s, w_accept, w_level_nxt;
    logic [HW-1:0]          w_hc_nxt;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_accept    = (w_s != r_level) && (r_dc == DC_LAST);
    assign w_level_nxt = w_accept ? w_s : r_level;

    // Hold count follows the level being committed this edge, so held drops
    // on the same edge that produces the fall pulse.
    always_comb begin
        w_hc_nxt = r_hc;
        if (!w_level_nxt)
            w_hc_nxt = '0;
        else if (r_level && (r_hc != HC_MAX))
            w_hc_nxt = r_hc + HW'(1);
    end

    // Plain shift chain into the clock domain, nothing between stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_sync <= {SYNC_STAGES{INIT}};
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end

    // Debounce: any cycle agreeing with level restarts the window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dc    <= '0;
            r_level <= INIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_accept &&  w_s;
            r_fall  <= w_accept && !w_s;
            if ((w_s == r_level) || w_accept) r_dc <= '0;
            else                              r_dc <= r_dc + DW'(1);
        end
    end

    // Long-press counter saturates; held registered from the next count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hc   <= '0;
            r_held <= 1'b0;
        end else begin
            r_hc   <= w_hc_nxt;
            r_held <= (w_hc_nxt == HC_MAX);
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_held  = r_held;
endmodule

// File: rtl/input_conditioner.sv
// Multi-lane pushbutton/switch conditioner: one independent input_channel
// per pin, gathered onto the conditioner bus.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                  CHANNELS        = 2,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = MS_CYCLES,
    parameter int                  HOLD_CYCLES     = CLK_HZ,
    parameter logic [CHANNELS-1:0] INIT_LEVEL      = {CHANNELS{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    input_conditioner_if.slave  bus
);
    logic [CHANNELS-1:0] w_pin;
    logic [CHANNELS-1:0] w_level, w_rise, w_fall, w_held;

    assign w_pin = bus.pin_in;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        input_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .INIT            (INIT_LEVEL[g])
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .i_pin   (w_pin[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g]),
            .o_held  (w_held[g])
        );
    end

    assign bus.level = w_level;
    assign bus.rise  = w_rise;
    assign bus.fall  = w_fall;
    assign bus.held  = w_held;
endmodule
